sd_stream_ctrl: RTL and testbench

Streaming controller for the sequence-detector datapath. It accepts parallel words from a requester over a valid/ready handshake and serialises them MSB-first, one bit per clock, into a programmable pattern matcher (sd_match_core). It counts matches, pulses dout per match, and drives led with the pattern on each match. The pattern is configured at run time, and the match history persists across word boundaries.

---
 rtl/sd_pkg.sv | 20 ++
 rtl/sd_match_core.sv | 47 ++++
 rtl/sd_stream_ctrl.sv | 121 ++++++++++++
 tb/tb_sd_stream_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the sequence-detector stream controller.
package sd_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } sd_state_e;

  localparam logic [3:0] SD_PAT_0110 = 4'b0110;

  localparam int unsigned SD_PAT_LEN_MIN = 2;
  localparam int unsigned SD_PAT_LEN_MAX = 8;
  localparam int unsigned SD_WORD_W_MIN  = 2;

  function automatic bit sd_cfg_ok(input int unsigned word_w, input int unsigned pat_len);
    return (word_w >= SD_WORD_W_MIN) && (pat_len >= SD_PAT_LEN_MIN) &&
           (pat_len <= SD_PAT_LEN_MAX);
  endfunction

endpackage

// File: rtl/sd_match_core.sv
// Serial pattern matcher: keeps the last PAT_LEN-1 bits plus a fill count.
// SD_STREAM_CTRL_NONOVERLAP_EN clears history after every match.
module sd_match_core
  import sd_pkg::*;
#(
  parameter int unsigned PAT_LEN = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_bit,
  input  logic               i_bit_vld,
  input  logic [PAT_LEN-1:0] i_pattern,
  input  logic               i_clr,
  output logic               o_match
);

  localparam int unsigned FILL_W = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-2:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic [PAT_LEN-1:0] w_window;
  logic               w_full;

  assign w_window = {r_hist, i_bit};
  assign w_full   = (r_fill == FILL_FULL);
  assign o_match  = i_bit_vld && w_full && (w_window == i_pattern);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_clr) begin
      r_hist <= '0;
      r_fill <= '0;
`ifdef SD_STREAM_CTRL_NONOVERLAP_EN
    end else if (o_match) begin
      r_hist <= '0;
      r_fill <= '0;
`endif
    end else if (i_bit_vld) begin
      r_hist <= w_window[PAT_LEN-2:0];
      if (!w_full) r_fill <= r_fill + 1'b1;
    end
  end

endmodule

// File: rtl/sd_stream_ctrl.sv
// Word-to-bit streaming controller feeding sd_match_core; counts and flags matches.
// Define SD_STREAM_CTRL_NONOVERLAP_EN for non-overlapping detection.
module sd_stream_ctrl
  import sd_pkg::*;
#(
  parameter int unsigned           WORD_W  = 8,
  parameter int unsigned           PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]    PAT_RST = PAT_LEN'(SD_PAT_0110),
  parameter int unsigned           CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_we,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cnt_clr,
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_data,
  output logic               in_ready,
  output logic               busy,
  output logic               dout,
  output logic [PAT_LEN-1:0] led,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int unsigned BCNT_W = $clog2(WORD_W);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  if (!sd_cfg_ok(WORD_W, PAT_LEN)) begin : g_bad_cfg
    $error("sd_stream_ctrl: unsupported WORD_W/PAT_LEN");
  end

  sd_state_e          r_state, w_state_next;
  logic [WORD_W-1:0]  r_shift;
  logic [BCNT_W-1:0]  r_bit_cnt;
  logic [PAT_LEN-1:0] r_pattern;
  logic               r_dout;
  logic [PAT_LEN-1:0] r_led;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_hs, w_cfg, w_bit_vld, w_match;

  assign w_hs      = in_valid && in_ready;
  assign w_bit_vld = (r_state == StShift);
  // Pattern writes are only safe between words; a same-cycle handshake wins.
  assign w_cfg     = cfg_we && (r_state == StIdle) && !w_hs;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_hs) w_state_next = StShift;
      StShift: if (r_bit_cnt == LAST_BIT && !w_hs) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (r_state)
      StIdle:  in_ready = 1'b1;
      StShift: begin
        busy     = 1'b1;
        in_ready = (r_bit_cnt == LAST_BIT);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_hs) begin
      r_shift   <= in_data;
      r_bit_cnt <= '0;
    end else if (r_state == StShift) begin
      r_shift   <= {r_shift[WORD_W-2:0], 1'b0};
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_pattern <= PAT_RST;
    else if (w_cfg) r_pattern <= cfg_pattern;
  end

  sd_match_core #(
    .PAT_LEN (PAT_LEN)
  ) u_match (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_bit     (r_shift[WORD_W-1]),
    .i_bit_vld (w_bit_vld),
    .i_pattern (r_pattern),
    .i_clr     (w_cfg),
    .o_match   (w_match)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout <= 1'b0;
      r_led  <= '0;
      r_cnt  <= '0;
    end else begin
      r_dout <= w_match;
      r_led  <= w_match ? r_pattern : '0;
      if (cnt_clr)                         r_cnt <= '0;
      else if (w_match && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign dout      = r_dout;
  assign led       = r_led;
  assign match_cnt = r_cnt;

endmodule

// File: tb/tb_sd_stream_ctrl.sv
// Scoreboard bench for sd_stream_ctrl: stimulus pushes per-bit expectations, a monitor checks.
module tb_sd_stream_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cfg_we;
  logic [3:0] cfg_pattern;
  logic       cnt_clr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, busy, dout;
  logic [3:0] led;
  logic [7:0] match_cnt;

  always #5 clk = ~clk;

  sd_stream_ctrl u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cnt_clr     (cnt_clr),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .busy        (busy),
    .dout        (dout),
    .led         (led),
    .match_cnt   (match_cnt)
  );

  // Hand-derived per-word match masks, bit 7 = first bit shifted.
`ifdef SD_STREAM_CTRL_NONOVERLAP_EN
  localparam logic [7:0] MASK_T1   = 8'b0001_0000;
  localparam logic [7:0] MASK_SAT0 = 8'b0001_0001;
  localparam logic [7:0] MASK_SATN = 8'b0001_0001;
`else
  localparam logic [7:0] MASK_T1   = 8'b0001_0010;
  localparam logic [7:0] MASK_SAT0 = 8'b0001_1111;
  localparam logic [7:0] MASK_SATN = 8'b1111_1111;
`endif

  typedef struct packed {
    logic       dout;
    logic [3:0] led;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_cnt;
  logic [3:0] cur_pat;
  logic       prev_busy = 1'b0;
  int         busy_run = 0;
  int         last_busy_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_busy = 1'b0;
      busy_run  = 0;
    end else begin
      if (prev_busy) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard underflow: got bit result expected none");
        end else begin
          mon_e = sb.pop_front();
          check("bit dout", dout, mon_e.dout);
          check("bit led", led, mon_e.led);
          check("bit match_cnt", match_cnt, mon_e.cnt);
        end
      end else begin
        check("idle dout", dout, 1'b0);
        check("idle led", led, 4'h0);
      end
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        last_busy_run = busy_run;
        busy_run = 0;
      end
      prev_busy = busy;
    end
  end

  // Called at a negedge; returns at the negedge after the handshake, or after the word.
  task automatic send_word(input logic [7:0] data, input logic [7:0] mask, input int clr_at,
                           input bit wait_done, input bit cfg_hold, output int waited);
    exp_t e;
    in_valid = 1'b1;
    in_data  = data;
    cfg_we   = cfg_hold;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready for handshake", in_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      e.dout = mask[7-i];
      if (i == clr_at) exp_cnt = 8'h00;
      else if (mask[7-i] && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'h01;
      e.led = mask[7-i] ? cur_pat : 4'h0;
      e.cnt = exp_cnt;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    if (wait_done) begin
      for (int i = 0; i < 8; i++) begin
        cnt_clr = (i == clr_at);
        @(negedge clk);
      end
      cnt_clr = 1'b0;
      cfg_we  = 1'b0;
    end
  endtask

  task automatic write_pat(input logic [3:0] p);
    cfg_we      = 1'b1;
    cfg_pattern = p;
    @(negedge clk);
    cfg_we  = 1'b0;
    cur_pat = p;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait for idle", busy, 1'b0);
  endtask

  initial begin
    int w;
    reset_n     = 1'b0;
    cfg_we      = 1'b0;
    cfg_pattern = 4'h0;
    cnt_clr     = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    exp_cnt     = 8'h00;
    cur_pat     = 4'b0110;
    repeat (3) @(negedge clk);
    check("reset dout", dout, 1'b0);
    check("reset led", led, 4'h0);
    check("reset match_cnt", match_cnt, 8'h00);
    check("reset busy", busy, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    check("released in_ready", in_ready, 1'b1);

    // Overlapping matches inside a single word.
    send_word(8'b0110_1100, MASK_T1, -1, 1'b1, 1'b0, w);
    @(negedge clk); #1;
    check("single word busy length", last_busy_run, 8);

    // Back-to-back words; match straddles the word boundary.
    send_word(8'b0000_0011, 8'b0000_0000, -1, 1'b0, 1'b0, w);
    send_word(8'b0101_1010, 8'b1000_0100, -1, 1'b1, 1'b0, w);
    check("last-bit in_ready wait", w, 7);
    @(negedge clk); #1;
    check("back-to-back busy length", last_busy_run, 16);

    // Pattern write during SHIFT (and with a same-cycle handshake) is ignored.
    write_pat(4'b0110);
    cfg_pattern = 4'b1001;
    send_word(8'b0110_0110, 8'b0001_0001, -1, 1'b1, 1'b1, w);
    write_pat(4'b1001);
    send_word(8'b1001_0000, 8'b0001_0000, -1, 1'b1, 1'b0, w);

    // Counter clear coinciding with a match wins over the increment.
    send_word(8'b1001_1001, 8'b0001_0001, 3, 1'b1, 1'b0, w);
    check("count after clear", match_cnt, 8'h01);

    // Saturate the match counter with an all-zero pattern.
    write_pat(4'b0000);
    send_word(8'h00, MASK_SAT0, -1, 1'b0, 1'b0, w);
    for (int k = 0; k < 130; k++) send_word(8'h00, MASK_SATN, -1, 1'b0, 1'b0, w);
    wait_idle();
    @(negedge clk);
    check("saturated match_cnt", match_cnt, 8'hFF);

    // Reset during bit 2 of a word.
    write_pat(4'b0110);
    send_word(8'b0110_0000, 8'b0000_0000, -1, 1'b0, 1'b0, w);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    sb.delete();
    exp_cnt = 8'h00;
    cur_pat = 4'b0110;
    #1;
    check("mid-word reset dout", dout, 1'b0);
    check("mid-word reset led", led, 4'h0);
    check("mid-word reset match_cnt", match_cnt, 8'h00);
    check("mid-word reset busy", busy, 1'b0);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    @(negedge clk);
    check("post-reset idle busy", busy, 1'b0);
    check("post-reset in_ready", in_ready, 1'b1);
    // A stale 01 history would match 0110 on the second bit here.
    send_word(8'b1000_0000, 8'b0000_0000, -1, 1'b1, 1'b0, w);

    begin
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("scoreboard drained", sb.size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
